// File: rtl/fastreadout_pkg.sv
// ============================================================================
// fastreadout_pkg : shared line-geometry helpers and line-capture state codes
// Rev 1.0
// ============================================================================
`default_nettype none

package fastreadout_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        WAIT = 1'b1
    } fill_state_e;

    function automatic int line_width(input int pixel_bits, input int pixels);
        return pixel_bits * pixels;
    endfunction

    function automatic int line_beats(input int width, input int lanes);
        return width / lanes;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_shift_reg.sv
// ============================================================================
// sipo_shift_reg : LANES-wide serial-in, W-wide parallel-out shift register
// Rev 1.0
// ============================================================================
`default_nettype none

module sipo_shift_reg #(
    parameter int W     = 32,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en_i,
    input  logic [LANES-1:0] data_i,
    output logic [W-1:0]     par_o,
    output logic [W-1:0]     par_next_o
);

    logic [W-1:0] sr_q;

    // par_next_o lets the owner capture a line on the same edge its last beat lands
    generate
        if (W > LANES) begin : g_shift
            assign par_next_o = {sr_q[W-LANES-1:0], data_i};
        end else begin : g_whole
            assign par_next_o = data_i;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else if (shift_en_i) begin
            sr_q <= par_next_o;
        end
    end

    assign par_o = sr_q;

endmodule

`default_nettype wire

// File: rtl/line_deserializer.sv
// ============================================================================
// line_deserializer : multi-lane serial line capture with double-buffered output
// Rev 1.0
// ============================================================================
`default_nettype none

module line_deserializer
    import fastreadout_pkg::*;
#(
    parameter int  PIXEL_BITS = 8,
    parameter int  PIXELS     = 1024,
    parameter int  LANES      = 1,
    parameter int  LINES      = 1024,
    localparam int W          = line_width(PIXEL_BITS, PIXELS),
    localparam int IDX_W      = (LINES > 1) ? $clog2(LINES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync,
    input  logic             in_valid,
    input  logic [LANES-1:0] in_data,
    output logic             in_ready,
    output logic             line_valid,
    input  logic             line_ready,
    output logic [W-1:0]     line_data,
    output logic [IDX_W-1:0] line_index,
    output logic             frame_last,
    output logic             overrun
);

    localparam int                BEATS     = line_beats(W, LANES);
    localparam int                CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  LAST_LINE = IDX_W'(LINES - 1);
    localparam logic [0:0]        S_FILL    = FILL;
    localparam logic [0:0]        S_WAIT    = WAIT;

    generate
        if (LANES < 1 || (PIXEL_BITS % LANES) != 0) begin : g_lanes_check
            $error("line_deserializer: LANES must divide PIXEL_BITS");
        end
    endgenerate

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             hold_valid_q, hold_valid_d;
    logic [W-1:0]     hold_data_q, hold_data_d;
    logic [IDX_W-1:0] hold_index_q, hold_index_d;
    logic             overrun_q, overrun_d;

    logic             beat_acc;
    logic             last_beat;
    logic             line_acc;
    logic             hold_free;
    logic             xfer;
    logic [W-1:0]     sr_par;
    logic [W-1:0]     sr_next;
    logic [W-1:0]     xfer_data;

    assign in_ready  = (state_q == S_FILL);
    assign beat_acc  = in_valid && in_ready && !sync;
    assign last_beat = beat_acc && (cnt_q == LAST_BEAT);
    assign line_acc  = hold_valid_q && line_ready;
    assign hold_free = !hold_valid_q || line_ready;
    // A parked line leaves WAIT on the same edge the held line is consumed
    assign xfer      = !sync && ((last_beat && hold_free) || (state_q == S_WAIT && line_acc));
    assign xfer_data = (state_q == S_WAIT) ? sr_par : sr_next;

    sipo_shift_reg #(
        .W     (W),
        .LANES (LANES)
    ) u_sipo (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (beat_acc),
        .data_i     (in_data),
        .par_o      (sr_par),
        .par_next_o (sr_next)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_index_d = hold_index_q;
        overrun_d    = overrun_q | (in_valid && !in_ready);

        if (sync) begin
            state_d = S_FILL;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            if (beat_acc) begin
                cnt_d = last_beat ? '0 : cnt_q + 1'b1;
            end
            if (last_beat && !hold_free) begin
                state_d = S_WAIT;
            end else if (state_q == S_WAIT && line_acc) begin
                state_d = S_FILL;
            end
        end

        // Holding register survives sync so a delivered-but-unread line is not lost
        if (xfer) begin
            hold_valid_d = 1'b1;
            hold_data_d  = xfer_data;
            hold_index_d = idx_q;
            idx_d        = (idx_q == LAST_LINE) ? '0 : idx_q + 1'b1;
        end else if (line_acc) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FILL;
            cnt_q        <= '0;
            idx_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_index_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_index_q <= hold_index_d;
            overrun_q    <= overrun_d;
        end
    end

    assign line_valid = hold_valid_q;
    assign line_data  = hold_data_q;
    assign line_index = hold_index_q;
    assign frame_last = hold_valid_q && (hold_index_q == LAST_LINE);
    assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_line_deserializer.sv
// ============================================================================
// tb_line_deserializer : scoreboard bench for line_deserializer (W=32, 2 lanes)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_line_deserializer;

    localparam int PB    = 8;
    localparam int PX    = 4;
    localparam int LN    = 2;
    localparam int NL    = 3;
    localparam int W     = PB * PX;
    localparam int BEATS = W / LN;

    logic          clk = 1'b0;
    logic          reset;
    logic          sync;
    logic          in_valid;
    logic [LN-1:0] in_data;
    logic          in_ready;
    logic          line_valid;
    logic          line_ready;
    logic [W-1:0]  line_data;
    logic [1:0]    line_index;
    logic          frame_last;
    logic          overrun;

    always #5 clk = ~clk;

    line_deserializer #(
        .PIXEL_BITS (PB),
        .PIXELS     (PX),
        .LANES      (LN),
        .LINES      (NL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sync       (sync),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .line_data  (line_data),
        .line_index (line_index),
        .frame_last (frame_last),
        .overrun    (overrun)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   idx;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_sr;
    int           m_cnt;
    int           m_idx;
    int           checks = 0;
    int           errors = 0;
    int           n_pop;
    int           stall_cnt;
    bit           rand_ready = 1'b0;
    bit           rand_gaps  = 1'b0;

    // One clock: evaluate the handshakes that the coming edge will perform, then advance.
    task automatic tick();
        exp_t e;
        if (rand_ready) line_ready = ($urandom_range(0, 3) != 0);
        if (line_valid && line_ready) begin
            n_pop++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_line got data=%h idx=%0d required no line", line_data, line_index);
            end else begin
                e = sb.pop_front();
                checks++;
                if (line_data !== e.data) begin
                    errors++;
                    $display("FAIL line_data got=%h required=%h", line_data, e.data);
                end
                checks++;
                if (line_index !== e.idx) begin
                    errors++;
                    $display("FAIL line_index got=%0d required=%0d", line_index, e.idx);
                end
                checks++;
                if (frame_last !== (e.idx == 2'(NL - 1))) begin
                    errors++;
                    $display("FAIL frame_last got=%b required=%b idx=%0d", frame_last, (e.idx == 2'(NL - 1)), e.idx);
                end
            end
        end
        if (in_valid && !in_ready) stall_cnt++;
        if (sync) begin
            m_cnt = 0;
            m_idx = 0;
        end else if (in_valid && in_ready) begin
            m_sr = {m_sr[W-LN-1:0], in_data};
            m_cnt++;
            if (m_cnt == BEATS) begin
                e.data = m_sr;
                e.idx  = 2'(m_idx);
                sb.push_back(e);
                m_idx = (m_idx + 1) % NL;
                m_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_clear();
        sb.delete();
        m_sr  = '0;
        m_cnt = 0;
        m_idx = 0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        sync       = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        line_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        n_pop     = 0;
        stall_cnt = 0;
    endtask

    task automatic send_beats(input logic [W-1:0] word, input int nbeats);
        int budget;
        bit acc;
        int gap;
        for (int i = 0; i < nbeats; i++) begin
            if (rand_gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                gap = $urandom_range(1, 3);
                for (int g = 0; g < gap; g++) tick();
            end
            in_valid = 1'b1;
            in_data  = word[W-1-LN*i -: LN];
            budget   = 0;
            do begin
                acc = in_ready;
                tick();
                budget++;
            end while (!acc && budget < 100);
            if (!acc) begin
                checks++; errors++;
                $display("FAIL beat_timeout beat=%0d in_ready=%b required=1", i, in_ready);
            end
        end
    endtask

    task automatic drain();
        int budget = 0;
        rand_ready = 1'b0;
        in_valid   = 1'b0;
        line_ready = 1'b1;
        while ((sb.size() != 0 || line_valid) && budget < 200) begin
            tick();
            budget++;
        end
        checks++;
        if (sb.size() != 0 || line_valid) begin
            errors++;
            $display("FAIL drain pending=%0d line_valid=%b required 0 and 0", sb.size(), line_valid);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        sync       = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        line_ready = 1'b0;
        @(negedge clk);
        checks++; if (in_ready   !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL rst_line_valid got=%b required=0", line_valid); end
        checks++; if (line_data  !== '0)   begin errors++; $display("FAIL rst_line_data got=%h required=0", line_data); end
        checks++; if (line_index !== 2'd0) begin errors++; $display("FAIL rst_line_index got=%0d required=0", line_index); end
        checks++; if (frame_last !== 1'b0) begin errors++; $display("FAIL rst_frame_last got=%b required=0", frame_last); end
        checks++; if (overrun    !== 1'b0) begin errors++; $display("FAIL rst_overrun got=%b required=0", overrun); end
        do_reset();
    endtask

    task automatic test_single_line();
        do_reset();
        line_ready = 1'b1;
        send_beats(32'hDEADBEEF, BEATS);
        checks++;
        if (line_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b required=1", line_valid); end
        checks++;
        if (line_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got=%h required=deadbeef", line_data); end
        checks++;
        if (line_index !== 2'd0) begin errors++; $display("FAIL single_index got=%0d required=0", line_index); end
        drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        line_ready = 1'b1;
        for (int l = 0; l < 4; l++) send_beats($urandom, BEATS);
        drain();
        checks++;
        if (stall_cnt !== 0) begin errors++; $display("FAIL b2b_in_ready_drops got=%0d required=0", stall_cnt); end
        checks++;
        if (n_pop !== 4) begin errors++; $display("FAIL b2b_lines got=%0d required=4", n_pop); end
    endtask

    task automatic test_park();
        do_reset();
        line_ready = 1'b0;
        send_beats(32'hA5A50F0F, BEATS);
        send_beats(32'h3C3CF00F, BEATS);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL park_in_ready got=%b required=0", in_ready); end
        in_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL park_overrun got=%b required=1", overrun); end
        checks++;
        if (line_data !== 32'hA5A50F0F) begin errors++; $display("FAIL park_hold_data got=%h required=a5a50f0f", line_data); end
        checks++;
        if (line_valid !== 1'b1) begin errors++; $display("FAIL park_hold_valid got=%b required=1", line_valid); end
        drain();
        checks++;
        if (n_pop !== 2) begin errors++; $display("FAIL park_lines got=%0d required=2", n_pop); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL park_in_ready_back got=%b required=1", in_ready); end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b required=1", overrun); end
    endtask

    task automatic test_sync();
        do_reset();
        line_ready = 1'b1;
        send_beats(32'h0BADF00D, BEATS);
        send_beats(32'hFFFF0000, 7);
        in_valid = 1'b0;
        sync     = 1'b1;
        tick();
        sync = 1'b0;
        send_beats(32'h12345678, BEATS);
        checks++;
        if (line_data !== 32'h12345678) begin errors++; $display("FAIL sync_data got=%h required=12345678", line_data); end
        checks++;
        if (line_index !== 2'd0) begin errors++; $display("FAIL sync_index got=%0d required=0", line_index); end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        line_ready = 1'b0;
        send_beats(32'hCAFEBABE, BEATS);
        send_beats(32'h55AA55AA, 9);
        in_valid = 1'b0;
        checks++;
        if (line_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b required=1", line_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL async_line_valid got=%b required=0", line_valid); end
        checks++; if (line_data  !== '0)   begin errors++; $display("FAIL async_line_data got=%h required=0", line_data); end
        checks++; if (in_ready   !== 1'b1) begin errors++; $display("FAIL async_in_ready got=%b required=1", in_ready); end
        checks++; if (line_index !== 2'd0) begin errors++; $display("FAIL async_line_index got=%0d required=0", line_index); end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        n_pop = 0;
        line_ready = 1'b1;
        send_beats(32'h87654321, BEATS);
        drain();
        checks++;
        if (n_pop !== 1) begin errors++; $display("FAIL post_reset_lines got=%0d required=1", n_pop); end
    endtask

    task automatic test_random();
        do_reset();
        rand_ready = 1'b1;
        rand_gaps  = 1'b1;
        for (int l = 0; l < 50; l++) send_beats($urandom, BEATS);
        rand_gaps = 1'b0;
        drain();
        checks++;
        if (n_pop !== 50) begin errors++; $display("FAIL random_lines got=%0d required=50", n_pop); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_line();
        test_back_to_back();
        test_park();
        test_sync();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/line_deserializer.md
# line_deserializer

Parametrised serial-to-parallel line capture stage for the fast-readout image path. It accepts pixel bits over 1..N serial lanes with a valid/ready handshake and assembles a full image line in a shift register. Completed lines are transferred into a double-buffered output register with their own valid/ready handshake, plus a line index and end-of-frame marker. It sits between the sensor/serial ingress and the line processing logic, and succeeds the single-lane `shift_register` + `load` scheme.

## Interface
- `PIXEL_BITS`, 8, bits per pixel
- `PIXELS`, 1024, pixels per line; line width `W = PIXELS*PIXEL_BITS`
- `LANES`, 1, serial bits accepted per beat; must divide `PIXEL_BITS` (elaboration error otherwise)
- `LINES`, 1024, lines per frame; line index wraps at this value
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `sync`  in  1  synchronous resync: discard partial line, line index to 0
- `in_valid`  in  1  `in_data` holds a beat
- `in_data`  in  LANES  beat bits; bit LANES-1 is earliest/most significant
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`
- `line_valid`  out  1  `line_data` holds a complete line
- `line_ready`  in  1  downstream accepts line when `line_valid && line_ready`
- `line_data`  out  W  assembled line; first bit received at bit W-1
- `line_index`  out  clog2(LINES)  index of the line in `line_data`
- `frame_last`  out  1  `line_index == LINES-1`, qualified by `line_valid`
- `overrun`  out  1  sticky: `in_valid` presented while `in_ready` low

## Operation
- Beat count per line `BEATS = W/LANES`; beat counter 0..BEATS-1.
- Accepted beat: `sr <= {sr[W-LANES-1:0], in_data}`, counter increments.
- Last beat (counter == BEATS-1) accepted: counter to 0; the complete line (including this beat) moves to the holding register if the holding register is empty or drained in the same cycle; otherwise enter WAIT.
- States: FILL (`in_ready=1`), WAIT (`in_ready=0`, full line parked in `sr`). WAIT -> FILL on the cycle `line_ready && line_valid`; `sr` moves to the holding register in that same edge.
- Holding register: `line_valid` sets on transfer, clears on accept without a simultaneous transfer. Accept and transfer in the same cycle keep `line_valid` high with new data.
- `line_index` increments on every transfer and wraps LINES-1 -> 0.
- `sync` (priority over beats, not over `reset`): counter to 0, state to FILL, parked line discarded, next-transfer index to 0. The holding register and `line_valid` are untouched, so a pending line remains deliverable.
- `overrun` sets when `in_valid && !in_ready`; cleared only by `reset`.
- Reset values: `in_ready=1`, `line_valid=0`, `line_data=0`, `line_index=0`, `frame_last=0`, `overrun=0`, `sr=0`, counter 0, FILL. Reset mid-line discards all data.

## Timing
- Ingress throughput: one beat per cycle, no bubbles while the downstream keeps up.
- Latency: last beat accepted at edge N -> `line_valid=1` with data and index after edge N.
- `in_ready` is registered state (FILL/WAIT), not combinational from `line_ready`. It rises the cycle after the WAIT -> FILL edge.
- `line_data`/`line_index` stable while `line_valid && !line_ready`.
- Back-to-back lines with `line_ready` held high: `line_valid` stays high, data changes every BEATS cycles.

## Structure
- Shared package `fastreadout_pkg`: `BEATS`/`W` derivation functions and the state enum `{FILL, WAIT}`.
- One natural sub-module: `sipo_shift_reg` (W, LANES; shift-enable, parallel out). The holding register, counters and FSM live in the top module.

## Test plan
Parameters for all scenarios: PIXEL_BITS=8, PIXELS=4, LANES=2, LINES=3 (W=32, BEATS=16).

- Stream 0xDEADBEEF MSB-first as 16 two-bit beats with `line_ready=1` -> `line_data=0xDEADBEEF`, `line_index=0`, `line_valid` one cycle after the 16th beat.
- Four lines back-to-back, `line_ready=1` -> indices 0,1,2,0; `frame_last` only with index 2; `in_ready` never drops.
- `line_ready=0`, send two full lines -> second line parks, `in_ready=0`. Keep driving `in_valid` -> `overrun=1`. Raise `line_ready` -> line 1 then line 2 delivered intact, `in_ready` back to 1.
- 7 beats, then `sync`, then a full line 0x12345678 -> `line_data=0x12345678`, `line_index=0`.
- Assert `reset` after 9 beats with `line_valid=1` -> all outputs at reset values immediately. The next full line arrives at index 0.
- Random `in_valid`/`line_ready` gaps over 50 lines vs a scoreboard model -> exact data/index match, no loss or duplication.
